// File: rtl/mult_issue_queue.sv
// ---------------------------------------------------------------------------
// mult_issue_queue
//
// In-order issue queue in front of the multiplier. Entries are dispatched at
// the tail, wait at the head until both source operands are valid, and are
// issued to the multiplier when it is ready. Every stored, not-yet-valid
// operand snoops the common data bus (CDB) and captures its value on a tag
// match.
//
// Entry layout (88 bits, MSB..LSB), shared by i_dispatch_data/o_issue_data:
//   [87:84] op            other pass-through fields
//   [83:78] rd_tag        destination tag
//   [77:72] rs1_tag
//   [71]    rs1_data_valid
//   [70:39] rs1_data
//   [38:33] rs2_tag
//   [32]    rs2_data_valid
//   [31:0]  rs2_data
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_flush           synchronous clear of the whole queue
//   i_dispatch_en     push request, i_dispatch_data is the entry
//   i_cdb_valid/tag/data  result broadcast snooped by stored operands
//   i_exe_ready       multiplier accepts an operation this cycle
//   o_issue_valid     head entry present with both operands valid
//   o_issue_data      head entry with its current operand values
//   o_full, o_empty, o_count  occupancy
//
// Optional feature: define CDB_DISPATCH_WAKEUP_EN to let an entry being
// dispatched capture a same-cycle CDB broadcast for its invalid operands.
// ---------------------------------------------------------------------------
module mult_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_dispatch_en,
  input  logic [87:0]              i_dispatch_data,
  input  logic                     i_cdb_valid,
  input  logic [5:0]               i_cdb_tag,
  input  logic [31:0]              i_cdb_data,
  input  logic                     i_exe_ready,
  output logic                     o_issue_valid,
  output logic [87:0]              o_issue_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  localparam int RS2_DATA_LSB = 0;
  localparam int RS2_VALID    = 32;
  localparam int RS2_TAG_LSB  = 33;
  localparam int RS1_DATA_LSB = 39;
  localparam int RS1_VALID    = 71;
  localparam int RS1_TAG_LSB  = 72;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [87:0]      entry_q [DEPTH];
  logic [87:0]      entry_d [DEPTH];

  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [87:0]      head;
  logic [87:0]      push_entry;
  logic             full;
  logic             empty;
  logic             fire;
  logic             push;

  // Capture a CDB result into any operand of the entry that is still waiting
  // on the broadcast tag; operands already valid are never overwritten.
  function automatic logic [87:0] wake(input logic [87:0] e,
                                       input logic        cdb_valid,
                                       input logic [5:0]  cdb_tag,
                                       input logic [31:0] cdb_data);
    logic [87:0] r;
    r = e;
    if (cdb_valid) begin
      if (!e[RS1_VALID] && (e[RS1_TAG_LSB +: 6] == cdb_tag)) begin
        r[RS1_DATA_LSB +: 32] = cdb_data;
        r[RS1_VALID]          = 1'b1;
      end
      if (!e[RS2_VALID] && (e[RS2_TAG_LSB +: 6] == cdb_tag)) begin
        r[RS2_DATA_LSB +: 32] = cdb_data;
        r[RS2_VALID]          = 1'b1;
      end
    end
    return r;
  endfunction

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];
  assign head   = entry_q[rd_idx];

  // Same index with differing wrap bits means the tail has lapped the head.
  assign full    = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign o_full  = full;
  assign o_empty = empty;

  // Issue readiness comes from registered state only, so a CDB capture is
  // visible one cycle after the broadcast.
  assign o_issue_valid = !empty && valid_q[rd_idx] && head[RS1_VALID] && head[RS2_VALID];
  assign o_issue_data  = head;

  assign fire = o_issue_valid && i_exe_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push = i_dispatch_en && (!full || fire);

`ifdef CDB_DISPATCH_WAKEUP_EN
  assign push_entry = wake(i_dispatch_data, i_cdb_valid, i_cdb_tag, i_cdb_data);
`else
  assign push_entry = i_dispatch_data;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = valid_q[i] ? wake(entry_q[i], i_cdb_valid, i_cdb_tag, i_cdb_data)
                              : entry_q[i];
    end

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      valid_d  = '0;
    end else begin
      if (fire) begin
        valid_d[rd_idx] = 1'b0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      // Applied after the pop so a push into the just-freed slot of a full
      // queue leaves that slot marked occupied.
      if (push) begin
        entry_d[wr_idx] = push_entry;
        valid_d[wr_idx] = 1'b1;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by valid_q and the
  // pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_mult_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_mult_issue_queue
//
// Self-checking bench for mult_issue_queue. Expected issue entries are queued
// when dispatch stimulus is driven and compared by a monitor whenever the
// DUT fires (o_issue_valid && i_exe_ready at the sampling point). Occupancy
// and readiness are checked directly after each clock edge.
// ---------------------------------------------------------------------------
module tb_mult_issue_queue;

  logic        clk;
  logic        rst;
  logic        i_flush;
  logic        i_dispatch_en;
  logic [87:0] i_dispatch_data;
  logic        i_cdb_valid;
  logic [5:0]  i_cdb_tag;
  logic [31:0] i_cdb_data;
  logic        i_exe_ready;
  logic        o_issue_valid;
  logic [87:0] o_issue_data;
  logic        o_full;
  logic        o_empty;
  logic [2:0]  o_count;

  int          checks;
  int          failures;
  logic [87:0] sb [$];
  logic [87:0] sb_exp;
  logic [87:0] ent [6];

  mult_issue_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_flush         (i_flush),
    .i_dispatch_en   (i_dispatch_en),
    .i_dispatch_data (i_dispatch_data),
    .i_cdb_valid     (i_cdb_valid),
    .i_cdb_tag       (i_cdb_tag),
    .i_cdb_data      (i_cdb_data),
    .i_exe_ready     (i_exe_ready),
    .o_issue_valid   (o_issue_valid),
    .o_issue_data    (o_issue_data),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_count         (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [87:0] mk(input logic [3:0] op, input logic [5:0] rd,
                                     input logic [5:0] t1, input logic v1, input logic [31:0] d1,
                                     input logic [5:0] t2, input logic v2, input logic [31:0] d2);
    return {op, rd, t1, v1, d1, t2, v2, d2};
  endfunction

  task automatic checkOutput(input string tag, input logic [87:0] actual, input logic [87:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic disp, input logic [87:0] data,
                               input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                               input logic rdy, input logic fl);
    i_dispatch_en   = disp;
    i_dispatch_data = data;
    i_cdb_valid     = cv;
    i_cdb_tag       = ct;
    i_cdb_data      = cd;
    i_exe_ready     = rdy;
    i_flush         = fl;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, '0, 1'b0, 6'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic dispatch(input logic [87:0] data, input logic [87:0] expected, input logic rdy);
    applyStimulus(1'b1, data, 1'b0, 6'd0, 32'd0, rdy, 1'b0);
    sb.push_back(expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a fire at the coming edge must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (!rst && !i_flush && o_issue_valid && i_exe_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 88'd1, 88'd0);
      end else begin
        sb_exp = sb.pop_front();
        checkOutput("issue_data", o_issue_data, sb_exp);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle(1'b0);
    step();
    checkOutput("rst_count", o_count, 0);
    checkOutput("rst_empty", o_empty, 1);
    checkOutput("rst_full", o_full, 0);
    checkOutput("rst_issue_valid", o_issue_valid, 0);
    step();
    rst = 1'b0;

    // Ready entry into an empty queue issues the next cycle.
    ent[0] = mk(4'h1, 6'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    dispatch(ent[0], ent[0], 1'b1);
    step();
    idle(1'b1);
    checkOutput("t1_issue_valid", o_issue_valid, 1);
    checkOutput("t1_rs1_data", o_issue_data[70:39], 32'd5);
    checkOutput("t1_rs2_data", o_issue_data[31:0], 32'd7);
    checkOutput("t1_rd_tag", o_issue_data[83:78], 6'd3);
    step();
    checkOutput("t1_empty", o_empty, 1);

    // rs1 waits on tag 9, woken by the CDB.
    dispatch(mk(4'h2, 6'd10, 6'd9, 1'b0, 32'd0, 6'd4, 1'b1, 32'h22),
             mk(4'h2, 6'd10, 6'd9, 1'b1, 32'h1234, 6'd4, 1'b1, 32'h22), 1'b1);
    step();
    idle(1'b1);
    checkOutput("t2_wait0", o_issue_valid, 0);
    step();
    checkOutput("t2_wait1", o_issue_valid, 0);
    applyStimulus(1'b0, '0, 1'b1, 6'd9, 32'h1234, 1'b1, 1'b0);
    step();
    idle(1'b1);
    checkOutput("t2_woken", o_issue_valid, 1);
    checkOutput("t2_rs1_data", o_issue_data[70:39], 32'h1234);
    step();
    checkOutput("t2_empty", o_empty, 1);

    // Fill, overflow drop, then push with pop while full.
    for (int i = 0; i < 6; i++) begin
      ent[i] = mk(4'h3, 6'(20 + i), 6'd0, 1'b1, 32'(100 + i), 6'd0, 1'b1, 32'(200 + i));
    end
    for (int i = 0; i < 4; i++) begin
      dispatch(ent[i], ent[i], 1'b0);
      step();
      checkOutput("t3_fill_count", o_count, 88'(i + 1));
    end
    applyStimulus(1'b1, ent[4], 1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    step();
    checkOutput("t3_drop_full", o_full, 1);
    checkOutput("t3_drop_count", o_count, 4);
    dispatch(ent[5], ent[5], 1'b1);
    step();
    checkOutput("t3_pushpop_count", o_count, 4);
    checkOutput("t3_pushpop_full", o_full, 1);
    idle(1'b1);
    repeat (4) step();
    checkOutput("t3_drained", o_empty, 1);

    // Unready head blocks a ready younger entry; valid operands ignore the CDB.
    dispatch(mk(4'h4, 6'd30, 6'd5, 1'b1, 32'h10, 6'd2, 1'b0, 32'd0),
             mk(4'h4, 6'd30, 6'd5, 1'b1, 32'h10, 6'd2, 1'b1, 32'h77), 1'b1);
    step();
    ent[1] = mk(4'h5, 6'd31, 6'd2, 1'b1, 32'h99, 6'd3, 1'b1, 32'h55);
    dispatch(ent[1], ent[1], 1'b1);
    step();
    idle(1'b1);
    checkOutput("t4_blocked0", o_issue_valid, 0);
    checkOutput("t4_count", o_count, 2);
    step();
    checkOutput("t4_blocked1", o_issue_valid, 0);
    applyStimulus(1'b0, '0, 1'b1, 6'd2, 32'h77, 1'b1, 1'b0);
    step();
    idle(1'b1);
    checkOutput("t4_head_ready", o_issue_valid, 1);
    checkOutput("t4_head_rd", o_issue_data[83:78], 6'd30);
    step();
    checkOutput("t4_next_ready", o_issue_valid, 1);
    checkOutput("t4_next_rd", o_issue_data[83:78], 6'd31);
    step();
    checkOutput("t4_empty", o_empty, 1);

    // Flush with a simultaneous push, then reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      dispatch(ent[i], ent[i], 1'b0);
      step();
    end
    applyStimulus(1'b1, ent[3], 1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
    step();
    idle(1'b1);
    sb.delete();
    checkOutput("t5_flush_count", o_count, 0);
    checkOutput("t5_flush_issue", o_issue_valid, 0);
    for (int i = 0; i < 2; i++) begin
      dispatch(ent[i], ent[i], 1'b0);
      step();
    end
    rst = 1'b1;
    idle(1'b1);
    step();
    rst = 1'b0;
    sb.delete();
    checkOutput("t5_rst_count", o_count, 0);
    checkOutput("t5_rst_issue", o_issue_valid, 0);
    dispatch(ent[2], ent[2], 1'b1);
    step();
    idle(1'b1);
    checkOutput("t5_after_rst_issue", o_issue_valid, 1);
    step();

    // Dispatch coinciding with a CDB broadcast of the waiting tag.
`ifdef CDB_DISPATCH_WAKEUP_EN
    applyStimulus(1'b1, mk(4'h6, 6'd40, 6'd1, 1'b1, 32'h1, 6'd4, 1'b0, 32'd0),
                  1'b1, 6'd4, 32'hAB, 1'b1, 1'b0);
    sb.push_back(mk(4'h6, 6'd40, 6'd1, 1'b1, 32'h1, 6'd4, 1'b1, 32'hAB));
    step();
    idle(1'b1);
    checkOutput("t6_wakeup_issue", o_issue_valid, 1);
    checkOutput("t6_rs2_data", o_issue_data[31:0], 32'hAB);
    step();
`else
    applyStimulus(1'b1, mk(4'h6, 6'd40, 6'd1, 1'b1, 32'h1, 6'd4, 1'b0, 32'd0),
                  1'b1, 6'd4, 32'hAB, 1'b1, 1'b0);
    sb.push_back(mk(4'h6, 6'd40, 6'd1, 1'b1, 32'h1, 6'd4, 1'b1, 32'hCD));
    step();
    idle(1'b1);
    checkOutput("t6_no_wakeup", o_issue_valid, 0);
    applyStimulus(1'b0, '0, 1'b1, 6'd4, 32'hCD, 1'b1, 1'b0);
    step();
    idle(1'b1);
    checkOutput("t6_late_wakeup", o_issue_valid, 1);
    step();
`endif
    checkOutput("t6_empty", o_empty, 1);

    checkOutput("sb_drained", 88'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
